// File: rtl/nlms_join_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nlms_join_pkg
//  Purpose  : Shared types and constants for the NLMS AXI-Stream lane joiner:
//             per-lane FIFO entry layout, join FSM states, counter sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package nlms_join_pkg;

  // Lane payload geometry. The FIFO entry layout is fixed here, so the top
  // level parameters default to these values.
  localparam int JOIN_ITEM_W = 32;
  localparam int JOIN_NIPC   = 1;
  localparam int JOIN_DATA_W = JOIN_ITEM_W * JOIN_NIPC;
  localparam int TS_W        = 64;

  // Event counters
  localparam int                 COUNT_W   = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  // One buffered beat of a single lane
  typedef struct packed {
    logic [JOIN_DATA_W-1:0] data;
    logic [JOIN_NIPC-1:0]   keep;
    logic                   last;
    logic [TS_W-1:0]        timestamp;
    logic                   has_time;
    logic                   eob;
  } lane_entry_t;

  // Join controller states
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    RESYNC = 1'b1
  } join_state_t;

  // Saturating increment for the event counters
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == COUNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nlms_join_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nlms_join_lane_fifo
//  Purpose  : Synchronous FIFO of lane_entry_t for one input lane. The head
//             entry is visible combinationally; depth is 2**FIFO_SIZE.
//  Revision : 1.0 - initial release
// ============================================================================
module nlms_join_lane_fifo
  import nlms_join_pkg::*;
#(
  parameter int FIFO_SIZE = 5
) (
  input  logic        axis_data_clk,
  input  logic        axis_data_rst_n,
  input  logic        push,
  input  lane_entry_t din,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output lane_entry_t head
);

  localparam int DEPTH = 1 << FIFO_SIZE;

  lane_entry_t          mem_q [DEPTH];
  logic [FIFO_SIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_SIZE:0]   rd_ptr_q, rd_ptr_d;
  logic                 do_push;
  logic                 do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_SIZE] != rd_ptr_q[FIFO_SIZE]) &&
                 (wr_ptr_q[FIFO_SIZE-1:0] == rd_ptr_q[FIFO_SIZE-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem_q[rd_ptr_q[FIFO_SIZE-1:0]];

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{FIFO_SIZE{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{FIFO_SIZE{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written at the tail
  always_ff @(posedge axis_data_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[FIFO_SIZE-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nlms_axis_join.sv
`default_nettype none
// ============================================================================
//  Module   : nlms_axis_join
//  Purpose  : Joins NUM_INPUTS AXI-Stream lanes into one lockstep stream. Each
//             output beat concatenates the head beat of every lane. When lane
//             packet boundaries disagree, every lane is flushed to the end of
//             its current packet and joining restarts on the next packet.
//  Options  : NLMS_JOIN_TS_CHECK_EN - count packet starts whose lane
//             timestamps disagree (otherwise ts_mismatch_count is zero).
//  Revision : 1.0 - initial release
// ============================================================================
module nlms_axis_join
  import nlms_join_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int ITEM_W     = JOIN_ITEM_W,
  parameter int NIPC       = JOIN_NIPC,
  parameter int FIFO_SIZE  = 5
) (
  input  logic                             axis_data_clk,
  input  logic                             axis_data_rst_n,
  input  logic [NUM_INPUTS*ITEM_W*NIPC-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS*NIPC-1:0]       s_axis_tkeep,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  input  logic [NUM_INPUTS*64-1:0]         s_axis_ttimestamp,
  input  logic [NUM_INPUTS-1:0]            s_axis_thas_time,
  input  logic [NUM_INPUTS-1:0]            s_axis_teob,
  output logic [NUM_INPUTS*ITEM_W*NIPC-1:0] m_axis_tdata,
  output logic [NIPC-1:0]                  m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [63:0]                      m_axis_ttimestamp,
  output logic                             m_axis_thas_time,
  output logic                             m_axis_teob,
  input  logic                             clear_count,
  output logic                             resync_active,
  output logic [15:0]                      misalign_count,
  output logic [15:0]                      ts_mismatch_count
);

  localparam int LANE_W = ITEM_W * NIPC;

  lane_entry_t               lane_in   [NUM_INPUTS];
  lane_entry_t               lane_head [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]     lane_full;
  logic [NUM_INPUTS-1:0]     lane_empty;
  logic [NUM_INPUTS-1:0]     lane_push;
  logic [NUM_INPUTS-1:0]     lane_pop;
  logic [NUM_INPUTS-1:0]     head_last;
  logic [NUM_INPUTS-1:0]     head_eob;
  logic [NUM_INPUTS-1:0]     head_has_time;
  logic [NUM_INPUTS-1:0]     lane_unused;

  join_state_t               state_q, state_d;
  logic [NUM_INPUTS-1:0]     done_q, done_d;
  logic [COUNT_W-1:0]        mis_cnt_q, mis_cnt_d;
  logic                      active_q, active_d;

  logic                      all_nv;
  logic                      last_agree;
  logic                      run_emit;
  logic                      misalign;
  logic                      beat_accept;

  // --------------------------------------------------------------------------
  // Per-lane input FIFOs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    assign lane_in[i] = lane_entry_t'{
      data:      s_axis_tdata[i*LANE_W +: LANE_W],
      keep:      s_axis_tkeep[i*NIPC +: NIPC],
      last:      s_axis_tlast[i],
      timestamp: s_axis_ttimestamp[i*64 +: 64],
      has_time:  s_axis_thas_time[i],
      eob:       s_axis_teob[i]
    };

    // Ready is held low through reset and the first cycle after it
    assign s_axis_tready[i] = active_q && !lane_full[i];
    assign lane_push[i]     = s_axis_tvalid[i] && s_axis_tready[i];

    assign head_last[i]     = lane_head[i].last;
    assign head_eob[i]      = lane_head[i].eob;
    assign head_has_time[i] = lane_head[i].has_time;

    // Only lane 0 drives keep/timestamp; other lanes' copies may go unread
    assign lane_unused[i]   = ^{lane_head[i].keep, lane_head[i].timestamp,
                                lane_head[i].has_time};

    assign m_axis_tdata[i*LANE_W +: LANE_W] = lane_head[i].data;

    nlms_join_lane_fifo #(
      .FIFO_SIZE (FIFO_SIZE)
    ) u_fifo (
      .axis_data_clk   (axis_data_clk),
      .axis_data_rst_n (axis_data_rst_n),
      .push            (lane_push[i]),
      .din             (lane_in[i]),
      .pop             (lane_pop[i]),
      .full            (lane_full[i]),
      .empty           (lane_empty[i]),
      .head            (lane_head[i])
    );
  end

  // --------------------------------------------------------------------------
  // Join decision
  // --------------------------------------------------------------------------
  assign all_nv      = ~|lane_empty;
  assign last_agree  = (&head_last) || !(|head_last);
  assign run_emit    = (state_q == RUN) && all_nv && last_agree;
  assign misalign    = (state_q == RUN) && all_nv && !last_agree;
  assign beat_accept = run_emit && m_axis_tready;

  // Output fields come straight from the FIFO heads, which only move on a pop,
  // so they hold steady while the downstream stalls.
  assign m_axis_tvalid     = run_emit;
  assign m_axis_tlast      = head_last[0];
  assign m_axis_tkeep      = lane_head[0].keep;
  assign m_axis_ttimestamp = lane_head[0].timestamp;
  assign m_axis_thas_time  = head_has_time[0];
  assign m_axis_teob       = |head_eob;
  assign resync_active     = (state_q == RESYNC);
  assign misalign_count    = mis_cnt_q;

  // Next-state, pop and misalignment counter logic
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    lane_pop = '0;
    active_d = 1'b1;

    case (state_q)
      RUN: begin
        if (beat_accept) begin
          lane_pop = '1;
        end
        if (misalign) begin
          state_d = RESYNC;
        end
      end
      RESYNC: begin
        // Each lane drains up to and including its own packet end, then waits
        lane_pop = ~done_q & ~lane_empty;
        done_d   = done_q | (lane_pop & head_last);
        if (&done_d) begin
          done_d  = '0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        done_d  = '0;
      end
    endcase

    if (clear_count) begin
      mis_cnt_d = '0;
    end else if (misalign) begin
      mis_cnt_d = sat_inc(mis_cnt_q);
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Join FSM and counter registers
  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) begin
      state_q   <= RUN;
      done_q    <= '0;
      mis_cnt_q <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      mis_cnt_q <= mis_cnt_d;
      active_q  <= active_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional timestamp agreement check at packet start
  // --------------------------------------------------------------------------
`ifdef NLMS_JOIN_TS_CHECK_EN
  logic               sop_q, sop_d;
  logic [COUNT_W-1:0] ts_cnt_q, ts_cnt_d;
  logic               ts_differs;
  logic               ts_event;

  // Any lane whose head timestamp differs from lane 0
  always_comb begin
    ts_differs = 1'b0;
    for (int i = 1; i < NUM_INPUTS; i++) begin
      if (lane_head[i].timestamp != lane_head[0].timestamp) begin
        ts_differs = 1'b1;
      end
    end
  end

  assign ts_event = beat_accept && sop_q && (&head_has_time) && ts_differs;

  // Start-of-packet tracking and saturating mismatch count
  always_comb begin
    sop_d = sop_q;
    if (beat_accept) begin
      sop_d = head_last[0];
    end else if ((state_q == RESYNC) && (state_d == RUN)) begin
      // A resync always leaves every lane at a packet boundary
      sop_d = 1'b1;
    end

    if (clear_count) begin
      ts_cnt_d = '0;
    end else if (ts_event) begin
      ts_cnt_d = sat_inc(ts_cnt_q);
    end else begin
      ts_cnt_d = ts_cnt_q;
    end
  end

  // Timestamp check registers
  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) begin
      sop_q    <= 1'b1;
      ts_cnt_q <= '0;
    end else begin
      sop_q    <= sop_d;
      ts_cnt_q <= ts_cnt_d;
    end
  end

  assign ts_mismatch_count = ts_cnt_q;
`else
  assign ts_mismatch_count = 16'h0;
`endif

endmodule
`default_nettype wire
